// File: rtl/pyramid_level_scheduler.sv
// Frame sequencer for the pyramidal LK flow: builds the pyramid, then runs the
// LK core once per level from coarse to fine, guarded by a per-phase watchdog.
module pyramid_level_scheduler #(
    parameter int IMAGE_WIDTH    = 320,
    parameter int IMAGE_HEIGHT   = 240,
    parameter int NUM_LEVELS     = 3,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic                            build_start,
    input  logic                            build_done,
    output logic                            lk_start,
    input  logic                            lk_done,
    output logic [$clog2(NUM_LEVELS):0]     lk_level,
    output logic [$clog2(IMAGE_WIDTH):0]    lk_width,
    output logic [$clog2(IMAGE_HEIGHT):0]   lk_height,
    output logic                            lk_seed_zero
);

    localparam int LW = $clog2(NUM_LEVELS) + 1;
    localparam int WW = $clog2(IMAGE_WIDTH) + 1;
    localparam int HW = $clog2(IMAGE_HEIGHT) + 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [LW-1:0] TOP_LEVEL = LW'(NUM_LEVELS - 1);
    localparam logic [LW-1:0] LEVEL_ONE = LW'(1);
    localparam logic [LW-1:0] LEVEL_ZERO = LW'(0);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] WD_ONE = CW'(1);
    localparam logic [CW-1:0] WD_ZERO = CW'(0);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_BUILD      = 3'd1,
        ST_BUILD_WAIT = 3'd2,
        ST_LK_ISSUE   = 3'd3,
        ST_LK_WAIT    = 3'd4,
        ST_NEXT_LVL   = 3'd5,
        ST_DONE       = 3'd6,
        ST_ERR        = 3'd7
    } state_t;

    function automatic logic [WW-1:0] level_width(input logic [LW-1:0] lvl);
        return WW'(IMAGE_WIDTH) >> lvl;
    endfunction

    function automatic logic [HW-1:0] level_height(input logic [LW-1:0] lvl);
        return HW'(IMAGE_HEIGHT) >> lvl;
    endfunction

    function automatic logic in_run(input state_t s);
        logic r;
        case (s)
            ST_BUILD, ST_BUILD_WAIT, ST_LK_ISSUE, ST_LK_WAIT, ST_NEXT_LVL: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    state_t          state_r, next_state_s;
    logic [CW-1:0]   wd_r, wd_s;
    logic [LW-1:0]   level_r, level_s;
    logic [WW-1:0]   width_r;
    logic [HW-1:0]   height_r;
    logic            seed_r, seed_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            error_r, error_s;
    logic            build_start_r, build_start_s;
    logic            lk_start_r, lk_start_s;
    logic            wd_expired_s;
    logic            load_s;
    logic            step_s;

    assign wd_expired_s = (wd_r >= WD_LAST);

    // State register plus registered copies of every output and the level datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            wd_r          <= WD_ZERO;
            level_r       <= TOP_LEVEL;
            width_r       <= level_width(TOP_LEVEL);
            height_r      <= level_height(TOP_LEVEL);
            seed_r        <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            build_start_r <= 1'b0;
            lk_start_r    <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            wd_r          <= wd_s;
            level_r       <= level_s;
            width_r       <= level_width(level_s);
            height_r      <= level_height(level_s);
            seed_r        <= seed_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            error_r       <= error_s;
            build_start_r <= build_start_s;
            lk_start_r    <= lk_start_s;
        end
    end

    // Next-state decode; abort overrides every transition, a done pulse beats watchdog expiry
    always_comb begin
        next_state_s = state_r;
        if (abort) begin
            if (in_run(state_r)) begin
                next_state_s = ST_IDLE;
            end else begin
                next_state_s = state_r;
            end
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        next_state_s = ST_BUILD;
                    end else begin
                        next_state_s = state_r;
                    end
                end
                ST_BUILD: next_state_s = ST_BUILD_WAIT;
                ST_BUILD_WAIT: begin
                    if (build_done) begin
                        next_state_s = ST_LK_ISSUE;
                    end else if (wd_expired_s) begin
                        next_state_s = ST_ERR;
                    end else begin
                        next_state_s = ST_BUILD_WAIT;
                    end
                end
                ST_LK_ISSUE: next_state_s = ST_LK_WAIT;
                ST_LK_WAIT: begin
                    if (lk_done) begin
                        next_state_s = ST_NEXT_LVL;
                    end else if (wd_expired_s) begin
                        next_state_s = ST_ERR;
                    end else begin
                        next_state_s = ST_LK_WAIT;
                    end
                end
                ST_NEXT_LVL: begin
                    if (level_r == LEVEL_ZERO) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_LK_ISSUE;
                    end
                end
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // Output decode: values computed from the upcoming state so that outputs leave a flop
    always_comb begin
        load_s        = (next_state_s == ST_BUILD);
        step_s        = (state_r == ST_NEXT_LVL) && (next_state_s == ST_LK_ISSUE);
        busy_s        = in_run(next_state_s);
        done_s        = (state_r == ST_NEXT_LVL) && (next_state_s == ST_DONE);
        build_start_s = (next_state_s == ST_BUILD);
        lk_start_s    = (next_state_s == ST_LK_ISSUE);
        error_s       = error_r;
        level_s       = level_r;
        seed_s        = seed_r;
        wd_s          = WD_ZERO;

        if (load_s) begin
            error_s = 1'b0;
        end else if (next_state_s == ST_ERR) begin
            error_s = 1'b1;
        end else begin
            error_s = error_r;
        end

        if (load_s) begin
            level_s = TOP_LEVEL;
            seed_s  = 1'b1;
        end else if (step_s) begin
            level_s = level_r - LEVEL_ONE;
            seed_s  = 1'b0;
        end else begin
            level_s = level_r;
            seed_s  = seed_r;
        end

        // The counter only runs while a wait phase continues; it holds at its last value
        if (((state_r == ST_BUILD_WAIT) || (state_r == ST_LK_WAIT)) && (next_state_s == state_r)) begin
            if (wd_r == WD_LAST) begin
                wd_s = wd_r;
            end else begin
                wd_s = wd_r + WD_ONE;
            end
        end else begin
            wd_s = WD_ZERO;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign build_start  = build_start_r;
    assign lk_start     = lk_start_r;
    assign lk_level     = level_r;
    assign lk_width     = width_r;
    assign lk_height    = height_r;
    assign lk_seed_zero = seed_r;

endmodule

// File: tb/tb_pyramid_level_scheduler.sv
// Randomized bench for pyramid_level_scheduler against a timeline model built
// from per-phase response delays, abort points and stray pulses.
module tb_pyramid_level_scheduler;

    localparam int T = 100;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, build_done, lk_done;
    logic       busy, done, error, build_start, lk_start;
    logic [2:0] lk_level;
    logic [9:0] lk_width;
    logic [8:0] lk_height;
    logic       lk_seed_zero;

    logic       start_1, abort_1, build_done_1, lk_done_1;
    logic       busy_1, done_1, error_1, build_start_1, lk_start_1;
    logic [0:0] lk_level_1;
    logic [9:0] lk_width_1;
    logic [8:0] lk_height_1;
    logic       lk_seed_zero_1;

    int checks = 0;
    int failures = 0;
    bit model_err = 1'b0;

    pyramid_level_scheduler #(.IMAGE_WIDTH(320), .IMAGE_HEIGHT(240), .NUM_LEVELS(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done), .error(error),
        .build_start(build_start), .build_done(build_done), .lk_start(lk_start), .lk_done(lk_done),
        .lk_level(lk_level), .lk_width(lk_width), .lk_height(lk_height), .lk_seed_zero(lk_seed_zero));

    pyramid_level_scheduler #(.IMAGE_WIDTH(320), .IMAGE_HEIGHT(240), .NUM_LEVELS(1), .TIMEOUT_CYCLES(T)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_1), .abort(abort_1), .busy(busy_1), .done(done_1), .error(error_1),
        .build_start(build_start_1), .build_done(build_done_1), .lk_start(lk_start_1), .lk_done(lk_done_1),
        .lk_level(lk_level_1), .lk_width(lk_width_1), .lk_height(lk_height_1), .lk_seed_zero(lk_seed_zero_1));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fields(input int lev, input bit seed);
        logic [2:0] l;
        logic [9:0] w;
        logic [8:0] h;
        l = 3'(lev);
        w = 10'(320 / (1 << lev));
        h = 9'(240 / (1 << lev));
        return 32'({l, w, h, seed});
    endfunction

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return T + int'($urandom_range(1, 20));
        else if (r == 1) return T;
        else return int'($urandom_range(1, 40));
    endfunction

    function automatic logic [31:0] actual_fields();
        return 32'({lk_level, lk_width, lk_height, lk_seed_zero});
    endfunction

    // bd/ldX: cycles from the start pulse to the response; abort_at: -1 none, 0 random, >0 absolute cycle
    task automatic run_frame(input int bd, input int ld0, input int ld1, input int ld2,
                             input int abort_at, input bit strays);
        int ld[3];
        int iss_t[3];
        int resp_t[3];
        int iss_n = 0;
        int end_t = 0;
        int stop;
        int t;
        int a = -1;
        int xs = -1;
        int slk = -1;
        int e_lev = 0;
        bit tout = 1'b0;
        bit ok;
        bit bdone, ldone, e_ls;
        logic [4:0] e_ctl;
        ld[0] = ld0; ld[1] = ld1; ld[2] = ld2;
        if (bd > T) begin
            end_t = T + 2;
            tout = 1'b1;
        end else begin
            t = bd + 2;
            for (int lev = N - 1; lev >= 0; lev--) begin
                iss_t[iss_n] = t;
                resp_t[iss_n] = t + ld[lev];
                iss_n++;
                if (ld[lev] > T) begin
                    end_t = t + T + 1;
                    tout = 1'b1;
                    break;
                end
                t = t + ld[lev] + 2;
                end_t = t;
            end
        end
        if (abort_at == 0) a = int'($urandom_range(1, end_t - 1));
        else if (abort_at > 0 && abort_at < end_t) a = abort_at;
        if (a > 0) begin
            end_t = a + 1;
            tout = 1'b0;
        end
        ok = !tout && (a < 0);
        if (strays) begin
            xs = int'($urandom_range(1, end_t - 1));
            slk = int'($urandom_range(1, bd + 1));
        end
        stop = end_t + 2;
        if (bd + 2 > stop) stop = bd + 2;
        for (int i = 0; i < iss_n; i++) if (resp_t[i] + 1 > stop) stop = resp_t[i] + 1;

        for (int c = 0; c <= stop; c++) begin
            @(posedge clk); #1;
            bdone = (c == bd + 1);
            ldone = (c == slk);
            e_ls = 1'b0;
            for (int i = 0; i < iss_n; i++) begin
                if (strays && c == iss_t[i]) bdone = 1'b1;
                if (c == resp_t[i]) ldone = 1'b1;
                if (c == iss_t[i] && (a < 0 || c <= a)) begin
                    e_ls = 1'b1;
                    e_lev = N - 1 - i;
                end
            end
            start = (c == 0) || (c == xs);
            abort = (c == a);
            build_done = bdone;
            lk_done = ldone;
            @(negedge clk);
            e_ctl[4] = (c >= 1) && (c < end_t);
            e_ctl[3] = ok && (c == end_t);
            e_ctl[2] = (c == 0) ? model_err : (tout && (c >= end_t));
            e_ctl[1] = (c == 1);
            e_ctl[0] = e_ls;
            check_val("ctl", 32'({busy, done, error, build_start, lk_start}), 32'(e_ctl));
            if (e_ls) check_val("lvl", actual_fields(), fields(e_lev, e_lev == N - 1));
        end
        start = 1'b0; abort = 1'b0; build_done = 1'b0; lk_done = 1'b0;
        model_err = tout;
    endtask

    initial begin
        logic [4:0] e1;
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; build_done = 1'b0; lk_done = 1'b0;
        start_1 = 1'b0; abort_1 = 1'b0; build_done_1 = 1'b0; lk_done_1 = 1'b0;
        #12;
        check_val("rst_ctl", 32'({busy, done, error, build_start, lk_start}), 32'(0));
        check_val("rst_lvl", actual_fields(), fields(2, 1'b1));
        check_val("rst_ctl1", 32'({busy_1, done_1, error_1, build_start_1, lk_start_1}), 32'(0));
        check_val("rst_lvl1", 32'({lk_level_1, lk_width_1, lk_height_1, lk_seed_zero_1}), fields(0, 1'b1) & 32'h7ffff);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(50, 100, 100, 100, -1, 1'b0);
        run_frame(50, 100, 500, 100, -1, 1'b0);
        run_frame(20, 30, 30, 30, -1, 1'b0);
        run_frame(20, 40, 40, 40, 32, 1'b0);
        run_frame(30, 40, 40, 40, -1, 1'b1);
        repeat (20) begin
            run_frame(pick_delay(), pick_delay(), pick_delay(), pick_delay(),
                      ($urandom_range(0, 3) == 0) ? 0 : -1, 1'($urandom_range(0, 1)));
        end
        run_frame(1, 1, 1, 1, -1, 1'b0);

        // reset asserted while level 1 is in its LK wait phase
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 build_done = 1'b1;
        @(posedge clk); #1 build_done = 1'b0;
        repeat (5) @(posedge clk);
        #1 lk_done = 1'b1;
        @(posedge clk); #1 lk_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_val("mid_ctl", 32'({busy, done, error, build_start, lk_start}), 32'(5'b10000));
        check_val("mid_lvl", actual_fields(), fields(1, 1'b0));
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_ctl", 32'({busy, done, error, build_start, lk_start}), 32'(0));
        check_val("arst_lvl", actual_fields(), fields(2, 1'b1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("post_rst", 32'({busy, done, error, build_start, lk_start}), 32'(0));
        end
        model_err = 1'b0;
        run_frame(15, 10, 10, 10, -1, 1'b0);

        // single-level instance with immediate responders
        for (int c = 0; c <= 8; c++) begin
            @(posedge clk); #1;
            start_1 = (c == 0);
            build_done_1 = (c == 2);
            lk_done_1 = (c == 4);
            @(negedge clk);
            e1 = {(c >= 1) && (c < 6), c == 6, 1'b0, c == 1, c == 3};
            check_val("n1_ctl", 32'({busy_1, done_1, error_1, build_start_1, lk_start_1}), 32'(e1));
            if (c == 3)
                check_val("n1_lvl", 32'({lk_level_1, lk_width_1, lk_height_1, lk_seed_zero_1}), fields(0, 1'b1) & 32'h7ffff);
        end
        start_1 = 1'b0; build_done_1 = 1'b0; lk_done_1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
